wt_pack2buf: RTL and testbench

- Parametrised weight-load packer between the MCIF read-response channel and the weight buffer.
- Gathers TOUT-lane response beats into TIN-lane buffer lines. The number of beats per line is selectable at run time, and unused upper lanes are zero-filled.
- Writes each line to a banked weight buffer and honours write-port backpressure.
- Controlled by the CSR start/done pair, with a synchronous abort.

---
 rtl/wt_pack2buf_pkg.sv | 36 +++
 rtl/wt_line_assembler.sv | 80 ++++++++
 rtl/wt_pack2buf.sv | 199 +++++++++++++++++++
 tb/tb_wt_pack2buf.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_pack2buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wt_pack2buf_pkg
//  Description : Shared defaults, derived constants, FSM encoding and helpers
//                for the weight-load packer (wt_pack2buf).
//  Revision    : 1.0 - initial release
// ============================================================================
package wt_pack2buf_pkg;

    // Default geometry
    localparam int WT_DW      = 8;
    localparam int WT_TOUT    = 8;
    localparam int WT_TIN     = 32;
    localparam int WT_BRAM_AW = 9;
    localparam int WT_BANK_W  = 3;
    localparam int WT_CNT_W   = 32;

    // Derived constants for the default geometry
    localparam int RATIO      = WT_TIN / WT_TOUT;
    localparam int LOG2_RATIO = $clog2(RATIO);
    localparam int ADDR_W     = WT_BANK_W + WT_BRAM_AW;

    // Job sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wt_state_e;

    // A beats-per-line request of 0 or above the lane ratio means "full line"
    function automatic int clamp_bpl(input int bpl, input int ratio);
        return ((bpl == 0) || (bpl > ratio)) ? ratio : bpl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wt_line_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : wt_line_assembler
//  Description : Packs TOUT-lane beats into a TIN-lane line, zero-fills the
//                unused upper slots and holds the finished line in an output
//                register until the buffer write port accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module wt_line_assembler #(
    parameter int DW    = 8,
    parameter int TOUT  = 8,
    parameter int TIN   = 32,
    parameter int BPL_W = $clog2(TIN / TOUT) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 beat_acc_i,
    input  logic [TOUT*DW-1:0]   beat_pd_i,
    input  logic [BPL_W-1:0]     bpl_i,
    output logic                 last_o,
    output logic                 wr_en_o,
    input  logic                 wr_rdy_i,
    output logic [TIN*DW-1:0]    wr_data_o
);

    localparam int SLOTS  = TIN / TOUT;
    localparam int SLOT_W = TOUT * DW;

    logic [BPL_W-1:0]  k_q;
    logic [TIN*DW-1:0] acc_q;
    logic [TIN*DW-1:0] data_q;
    logic              en_q;
    logic [TIN*DW-1:0] w_line;

    // The beat currently being accepted is the last one of its line
    assign last_o    = (k_q == (bpl_i - BPL_W'(1)));
    assign wr_en_o   = en_q;
    assign wr_data_o = data_q;

    // Accumulator image with the incoming beat merged in; slots at or above
    // the packing depth are forced to zero
    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        assign w_line[s*SLOT_W +: SLOT_W] =
            (BPL_W'(s) >= bpl_i)  ? '0 :
            (k_q == BPL_W'(s))    ? beat_pd_i :
                                    acc_q[s*SLOT_W +: SLOT_W];
    end

    // Beat packing and output line register that holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            acc_q  <= '0;
            data_q <= '0;
            en_q   <= 1'b0;
        end else if (clear_i) begin
            k_q    <= '0;
            acc_q  <= '0;
            en_q   <= 1'b0;
        end else begin
            if (en_q && wr_rdy_i) begin
                en_q <= 1'b0;
            end
            if (beat_acc_i) begin
                if (last_o) begin
                    data_q <= w_line;
                    en_q   <= 1'b1;
                    k_q    <= '0;
                    acc_q  <= '0;
                end else begin
                    acc_q  <= w_line;
                    k_q    <= k_q + BPL_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wt_pack2buf.sv
`default_nettype none
// ============================================================================
//  Module      : wt_pack2buf
//  Description : Weight-load packer between the MCIF read-response channel
//                and the banked weight buffer. Owns the job FSM, line
//                addressing, completion counters and the optional checksum.
//                Optional feature macro: WT_PACK2BUF_CHKSUM_EN (adds chksum).
//  Revision    : 1.0 - initial release
// ============================================================================
module wt_pack2buf
    import wt_pack2buf_pkg::*;
#(
    parameter int DW      = WT_DW,
    parameter int TOUT    = WT_TOUT,
    parameter int TIN     = WT_TIN,
    parameter int BRAM_AW = WT_BRAM_AW,
    parameter int BANK_W  = WT_BANK_W,
    parameter int CNT_W   = WT_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CNT_W-1:0]             line_num,
    input  logic [$clog2(TIN/TOUT):0]    beats_per_line,
    input  logic [BANK_W-1:0]            base_bank,
    output logic                         busy,
    output logic                         done,
    input  logic                         rd_resp_vld,
    output logic                         rd_resp_rdy,
    input  logic [TOUT*DW-1:0]           rd_resp_pd,
    output logic                         rd_fifo_pop,
    output logic                         buf_wr_en,
    input  logic                         buf_wr_rdy,
    output logic [BANK_W+BRAM_AW-1:0]    buf_wr_addr,
    output logic [TIN*DW-1:0]            buf_wr_data,
    output logic                         wt_addr_updt,
`ifdef WT_PACK2BUF_CHKSUM_EN
    output logic [31:0]                  chksum,
`endif
    output logic [CNT_W-1:0]             wt_lines_done
);

    localparam int BEAT_RATIO = TIN / TOUT;
    localparam int BPL_W      = $clog2(BEAT_RATIO) + 1;
    localparam int WR_AW      = BANK_W + BRAM_AW;

    wt_state_e         state_q, state_d;
    logic              done_q, done_d;
    logic [BPL_W-1:0]  bpl_q;
    logic [BANK_W-1:0] base_bank_q;
    logic [CNT_W-1:0]  line_num_q;
    logic [CNT_W-1:0]  lines_loaded_q;
    logic [CNT_W-1:0]  line_idx_q;

    logic              w_start_acc;
    logic              w_job_start;
    logic              w_last_beat;
    logic              w_wr_en;
    logic              w_wr_hs;
    logic              w_pop;
    logic              w_final_beat;
    logic [BPL_W-1:0]  w_bpl_clamped;

    // A start is only honoured from IDLE and loses to a simultaneous abort
    assign w_start_acc   = (state_q == ST_IDLE) && start && !abort;
    assign w_job_start   = w_start_acc && (line_num != '0);
    assign w_bpl_clamped = BPL_W'(clamp_bpl(int'(beats_per_line), BEAT_RATIO));

    assign w_wr_hs       = w_wr_en && buf_wr_rdy;
    // The last beat of a line stalls only while the previous line is still
    // waiting for the buffer
    assign rd_resp_rdy   = (state_q == ST_RUN) && !(w_last_beat && w_wr_en && !buf_wr_rdy);
    assign w_pop         = rd_resp_vld && rd_resp_rdy;
    assign w_final_beat  = w_pop && w_last_beat && (lines_loaded_q == (line_num_q - CNT_W'(1)));

    assign rd_fifo_pop   = w_pop;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign buf_wr_en     = w_wr_en;
    assign wt_addr_updt  = w_wr_hs;
    assign wt_lines_done = line_idx_q;
    // Bank base plus running line index; wraps past the top bank
    assign buf_wr_addr   = {base_bank_q, {BRAM_AW{1'b0}}} + line_idx_q[WR_AW-1:0];

    wt_line_assembler #(
        .DW    (DW),
        .TOUT  (TOUT),
        .TIN   (TIN),
        .BPL_W (BPL_W)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (abort || w_job_start),
        .beat_acc_i (w_pop),
        .beat_pd_i  (rd_resp_pd),
        .bpl_i      (bpl_q),
        .last_o     (w_last_beat),
        .wr_en_o    (w_wr_en),
        .wr_rdy_i   (buf_wr_rdy),
        .wr_data_o  (buf_wr_data)
    );

    // FSM state and completion-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state and done decode; abort overrides every transition
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (line_num != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_final_beat) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_wr_hs) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Job configuration latch and line counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpl_q          <= '0;
            base_bank_q    <= '0;
            line_num_q     <= '0;
            lines_loaded_q <= '0;
            line_idx_q     <= '0;
        end else if (w_job_start) begin
            bpl_q          <= w_bpl_clamped;
            base_bank_q    <= base_bank;
            line_num_q     <= line_num;
            lines_loaded_q <= '0;
            line_idx_q     <= '0;
        end else begin
            if (w_wr_hs) begin
                line_idx_q <= line_idx_q + CNT_W'(1);
            end
            if (w_pop && w_last_beat) begin
                lines_loaded_q <= lines_loaded_q + CNT_W'(1);
            end
        end
    end

`ifdef WT_PACK2BUF_CHKSUM_EN
    logic [31:0] chksum_q;
    logic [31:0] w_beat_sum;

    assign chksum = chksum_q;

    // Zero-extended sum of all lanes of the presented beat
    always_comb begin
        w_beat_sum = '0;
        for (int l = 0; l < TOUT; l++) begin
            w_beat_sum = w_beat_sum + 32'(rd_resp_pd[l*DW +: DW]);
        end
    end

    // Running checksum of accepted beats; cleared on start or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum_q <= '0;
        end else if (abort || w_start_acc) begin
            chksum_q <= '0;
        end else if (w_pop) begin
            chksum_q <= chksum_q + w_beat_sum;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wt_pack2buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wt_pack2buf
//  Description : Randomised self-checking bench for wt_pack2buf with a
//                line-level reference model (beat tables, expected lines and
//                addresses computed up front per job).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wt_pack2buf;

    localparam int DW      = 8;
    localparam int TOUT    = 8;
    localparam int TIN     = 32;
    localparam int BRAM_AW = 9;
    localparam int BANK_W  = 3;
    localparam int CNT_W   = 32;
    localparam int RATIO   = TIN / TOUT;
    localparam int BPL_W   = $clog2(RATIO) + 1;
    localparam int AW      = BANK_W + BRAM_AW;
    localparam int BEAT_W  = TOUT * DW;
    localparam int LINE_W  = TIN * DW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  line_num;
    logic [BPL_W-1:0]  beats_per_line;
    logic [BANK_W-1:0] base_bank;
    logic              busy;
    logic              done;
    logic              rd_resp_vld;
    logic              rd_resp_rdy;
    logic [BEAT_W-1:0] rd_resp_pd;
    logic              rd_fifo_pop;
    logic              buf_wr_en;
    logic              buf_wr_rdy;
    logic [AW-1:0]     buf_wr_addr;
    logic [LINE_W-1:0] buf_wr_data;
    logic              wt_addr_updt;
    logic [CNT_W-1:0]  wt_lines_done;
`ifdef WT_PACK2BUF_CHKSUM_EN
    logic [31:0]       chksum;
`endif

    wt_pack2buf dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .line_num       (line_num),
        .beats_per_line (beats_per_line),
        .base_bank      (base_bank),
        .busy           (busy),
        .done           (done),
        .rd_resp_vld    (rd_resp_vld),
        .rd_resp_rdy    (rd_resp_rdy),
        .rd_resp_pd     (rd_resp_pd),
        .rd_fifo_pop    (rd_fifo_pop),
        .buf_wr_en      (buf_wr_en),
        .buf_wr_rdy     (buf_wr_rdy),
        .buf_wr_addr    (buf_wr_addr),
        .buf_wr_data    (buf_wr_data),
        .wt_addr_updt   (wt_addr_updt),
`ifdef WT_PACK2BUF_CHKSUM_EN
        .chksum         (chksum),
`endif
        .wt_lines_done  (wt_lines_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [BEAT_W-1:0] beats[$];
    logic [LINE_W-1:0] exp_lines[$];
    logic [AW-1:0]     exp_addr[$];
    int                bi, wi, total_beats, eff_bpl, n_lines;
    int                ld_exp;
    bit                job_on, run_on, done_exp, hold_valid, ones_mode;
    logic [AW-1:0]     hold_addr;
    logic [LINE_W-1:0] hold_data;
    logic [31:0]       sum_exp;

    task automatic check_val(input string tag, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Compare one cycle of DUT outputs against the model, then advance it
    task automatic sample(input bit abort_now);
        bit exp_rdy;
        bit hs;
        check_val("busy", busy, job_on);
        check_val("done", done, done_exp);
        check_val("lines_done", wt_lines_done, ld_exp);
        exp_rdy = run_on && (bi < total_beats) &&
                  !(((bi % eff_bpl) == eff_bpl - 1) && buf_wr_en && !buf_wr_rdy);
        check_val("rd_resp_rdy", rd_resp_rdy, exp_rdy);
        check_val("rd_fifo_pop", rd_fifo_pop, rd_resp_vld & exp_rdy);
        if (!job_on) check_val("idle_wr_en", buf_wr_en, 0);
        if (hold_valid) begin
            check_val("hold_en", buf_wr_en, 1);
            check_val("hold_addr", buf_wr_addr, hold_addr);
            check_val("hold_data", buf_wr_data, hold_data);
        end
        hs = buf_wr_en && buf_wr_rdy;
        check_val("wt_addr_updt", wt_addr_updt, hs);
        done_exp = 1'b0;
        if (hs) begin
            if (wi < exp_lines.size()) begin
                check_val("wr_addr", buf_wr_addr, exp_addr[wi]);
                check_val("wr_data", buf_wr_data, exp_lines[wi]);
            end else begin
                check_val("write_in_range", wi, exp_lines.size() - 1);
            end
            wi++;
            ld_exp++;
            if (job_on && wi == n_lines && !abort_now) begin
                done_exp = 1'b1;
                job_on   = 1'b0;
                run_on   = 1'b0;
            end
        end
        hold_valid = buf_wr_en && !buf_wr_rdy && !abort_now;
        hold_addr  = buf_wr_addr;
        hold_data  = buf_wr_data;
        if (rd_fifo_pop) begin
            for (int l = 0; l < TOUT; l++) sum_exp += 32'(rd_resp_pd[l*DW +: DW]);
            bi++;
        end
        if (abort_now) begin
            job_on  = 1'b0;
            run_on  = 1'b0;
            sum_exp = '0;
        end
    endtask

    task automatic run_job(input int bpl_in, input int nlines, input int base,
                           input int vld_pct, input int rdy_pct, input int abort_at,
                           input bit stall0, input int rst_at);
        logic [BEAT_W-1:0] b;
        logic [LINE_W-1:0] line;
        int  cyc, tail, stall_cnt;
        bit  aborted, abort_now;
        eff_bpl = ((bpl_in == 0) || (bpl_in > RATIO)) ? RATIO : bpl_in;
        beats.delete(); exp_lines.delete(); exp_addr.delete();
        for (int i = 0; i < nlines; i++) begin
            line = '0;
            for (int j = 0; j < eff_bpl; j++) begin
                b = ones_mode ? {TOUT{8'h01}} : {$urandom, $urandom};
                beats.push_back(b);
                line[j*BEAT_W +: BEAT_W] = b;
            end
            exp_lines.push_back(line);
            exp_addr.push_back(AW'(base * (1 << BRAM_AW) + i));
        end
        total_beats = nlines * eff_bpl;
        n_lines = nlines;
        bi = 0;
        wi = 0;

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0;
        line_num = CNT_W'(nlines); beats_per_line = BPL_W'(bpl_in); base_bank = BANK_W'(base);
        rd_resp_vld = $urandom_range(1); rd_resp_pd = {$urandom, $urandom}; buf_wr_rdy = 1'b1;
        @(negedge clk);
        sample(1'b0);
        sum_exp = '0;
        if (nlines == 0) begin
            done_exp = 1'b1;
        end else begin
            job_on = 1'b1; run_on = 1'b1; ld_exp = 0;
        end

        cyc = 0; tail = -1; stall_cnt = 0; aborted = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_at >= 0 && cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_val("rst_busy", busy, 0);
                check_val("rst_wr_en", buf_wr_en, 0);
                check_val("rst_rdy", rd_resp_rdy, 0);
                check_val("rst_lines_done", wt_lines_done, 0);
                check_val("rst_addr", buf_wr_addr, 0);
                job_on = 0; run_on = 0; done_exp = 0; hold_valid = 0; ld_exp = 0; sum_exp = '0;
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            abort_now   = (abort_at >= 0) && !aborted && job_on && (wi >= abort_at);
            abort       = abort_now;
            rd_resp_vld = ($urandom_range(99) < vld_pct);
            rd_resp_pd  = (bi < total_beats) ? beats[bi] : {$urandom, $urandom};
            if (stall0 && buf_wr_en && wi == 0 && stall_cnt < 5) begin
                buf_wr_rdy = 1'b0;
                stall_cnt++;
            end else begin
                buf_wr_rdy = ($urandom_range(99) < rdy_pct);
            end
            start          = run_on && (bi < total_beats) && !abort_now && ($urandom_range(15) == 0);
            line_num       = 5;
            beats_per_line = BPL_W'($urandom_range(7));
            base_bank      = BANK_W'($urandom_range(7));
            @(negedge clk);
            sample(abort_now);
            if (abort_now) aborted = 1'b1;
            cyc++;
            if (tail < 0 && !job_on && !done_exp) tail = 3;
            if (tail == 0) break;
            if (tail > 0) tail--;
            if (cyc > 20000) begin
                check_val("timeout", cyc, 20000);
                break;
            end
        end
        start = 1'b0; abort = 1'b0; rd_resp_vld = 1'b0;
`ifdef WT_PACK2BUF_CHKSUM_EN
        check_val("chksum", chksum, sum_exp);
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; line_num = '0; beats_per_line = '0;
        base_bank = '0; rd_resp_vld = 1'b1; rd_resp_pd = '1; buf_wr_rdy = 1'b1;
        bi = 0; wi = 0; total_beats = 0; eff_bpl = RATIO; n_lines = 0; ld_exp = 0;
        job_on = 0; run_on = 0; done_exp = 0; hold_valid = 0; ones_mode = 0; sum_exp = '0;
        hold_addr = '0; hold_data = '0;

        repeat (2) @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_wr_en", buf_wr_en, 0);
        check_val("reset_addr", buf_wr_addr, 0);
        check_val("reset_data", buf_wr_data, 0);
        check_val("reset_updt", wt_addr_updt, 0);
        check_val("reset_lines_done", wt_lines_done, 0);
        check_val("reset_rdy", rd_resp_rdy, 0);
        check_val("reset_pop", rd_fifo_pop, 0);
`ifdef WT_PACK2BUF_CHKSUM_EN
        check_val("reset_chksum", chksum, 0);
`endif
        rst_n = 1'b1;
        rd_resp_vld = 1'b0;

        run_job(4, 3, 2, 100, 100, -1, 0, -1);     // basic job, addresses 0x400..0x402
        run_job(2, 2, 1, 100, 100, -1, 0, -1);     // zero-fill upper lanes
        run_job(7, 3, 0, 80, 70, -1, 0, -1);       // clamp 7 -> 4
        run_job(0, 2, 5, 90, 80, -1, 0, -1);       // clamp 0 -> 4
        run_job(4, 3, 0, 100, 100, -1, 1, -1);     // backpressure on line 0
        run_job(3, 0, 4, 100, 100, -1, 0, -1);     // zero-length job
        run_job(4, 5, 3, 100, 60, 2, 0, -1);       // abort after line 1 written
        run_job(4, 600, 7, 100, 90, -1, 0, -1);    // address wrap 0xFFF -> 0x000
        for (int t = 0; t < 6; t++) begin
            run_job($urandom_range(7), $urandom_range(1, 12), $urandom_range(7),
                    $urandom_range(50, 100), $urandom_range(40, 100), -1, 0, -1);
        end
        run_job(4, 8, 1, 100, 100, -1, 0, 20);     // reset mid-job
        run_job(1, 4, 6, 70, 70, -1, 0, -1);       // recovery after reset
        ones_mode = 1'b1;
        run_job(4, 1, 0, 100, 100, -1, 0, -1);     // all-ones lanes
`ifdef WT_PACK2BUF_CHKSUM_EN
        check_val("chksum_ones", chksum, 32);
`endif
        ones_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
